// File: rtl/roi_axis_fifo_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// roi_axis_fifo_if : ROI pixel stream in/out plus FIFO status and control
// rev 1.0
// ---------------------------------------------------------------------------
interface roi_axis_fifo_if #(
   parameter int BIT_D = 8,
   parameter int DEPTH = 16,
   parameter int CNT_W = 21
);
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic [BIT_D-1:0] tdata_i;
   logic             tvalid_i;
   logic             tlast_i;
   logic             tready_i;
   logic             ovf_clr_i;

   logic [BIT_D-1:0] tdata_o;
   logic             tvalid_o;
   logic             tlast_o;
   logic [LVL_W-1:0] level_o;
   logic [CNT_W-1:0] frame_len_o;
   logic             frame_done_o;
   logic             frame_act_o;
   logic             ovf_o;

   // FIFO side
   modport slave (
      input  tdata_i, tvalid_i, tlast_i, tready_i, ovf_clr_i,
      output tdata_o, tvalid_o, tlast_o, level_o, frame_len_o,
             frame_done_o, frame_act_o, ovf_o
   );

   // Stream source / sink side
   modport master (
      output tdata_i, tvalid_i, tlast_i, tready_i, ovf_clr_i,
      input  tdata_o, tvalid_o, tlast_o, level_o, frame_len_o,
             frame_done_o, frame_act_o, ovf_o
   );
endinterface
`default_nettype wire

// File: rtl/roi_axis_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// roi_axis_fifo : FWFT buffer for the non-stallable ROI stream + frame tracker
// rev 1.0
// ---------------------------------------------------------------------------
module roi_axis_fifo #(
   parameter int BIT_D = 8,
   parameter int DEPTH = 16,
   parameter int CNT_W = 21
) (
   input  wire logic       clk_i,
   input  wire logic       arst_i,
   roi_axis_fifo_if.slave  bus
);
   localparam int               PTR_W    = $clog2(DEPTH);
   localparam int               LVL_W    = PTR_W + 1;
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   logic [BIT_D:0]   mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             ovf_q, ovf_d;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
   logic [CNT_W-1:0] frame_len_q, frame_len_d;
   logic             frame_done_q, frame_done_d;

   logic             rd_en, wr_en, drop;
   logic             out_valid;
   logic [BIT_D:0]   head;
   logic [CNT_W-1:0] pix_inc;

   // The source cannot be stalled, so a beat arriving at a full FIFO with no
   // simultaneous read is simply lost and flagged.
   always_comb begin
      out_valid = (level_q != '0);
      rd_en     = out_valid && bus.tready_i;
      wr_en     = bus.tvalid_i && ((level_q != LVL_FULL) || rd_en);
      drop      = bus.tvalid_i && !wr_en;

      wr_ptr_d  = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d  = rd_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

      level_d = level_q;
      if (wr_en && !rd_en) begin
         level_d = level_q + LVL_W'(1);
      end else if (rd_en && !wr_en) begin
         level_d = level_q - LVL_W'(1);
      end

      ovf_d = ovf_q;
      if (drop) begin
         ovf_d = 1'b1;
      end else if (bus.ovf_clr_i) begin
         ovf_d = 1'b0;
      end
   end

   // Counts every input beat, accepted or dropped.
   always_comb begin
      pix_inc      = (pix_cnt_q == CNT_MAX) ? CNT_MAX : pix_cnt_q + CNT_W'(1);
      state_d      = state_q;
      pix_cnt_d    = pix_cnt_q;
      frame_len_d  = frame_len_q;
      frame_done_d = 1'b0;

      case (state_q)
         ST_IDLE:   if (bus.tvalid_i && !bus.tlast_i) state_d = ST_ACTIVE;
         ST_ACTIVE: if (bus.tvalid_i &&  bus.tlast_i) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      if (bus.tvalid_i) begin
         if (bus.tlast_i) begin
            frame_len_d  = pix_inc;
            pix_cnt_d    = '0;
            frame_done_d = 1'b1;
         end else begin
            pix_cnt_d    = pix_inc;
         end
      end
   end

   always_ff @(posedge clk_i or negedge arst_i) begin
      if (!arst_i) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         ovf_q        <= 1'b0;
         state_q      <= ST_IDLE;
         pix_cnt_q    <= '0;
         frame_len_q  <= '0;
         frame_done_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         ovf_q        <= ovf_d;
         state_q      <= state_d;
         pix_cnt_q    <= pix_cnt_d;
         frame_len_q  <= frame_len_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Storage carries no reset.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= {bus.tlast_i, bus.tdata_i};
      end
   end

   assign head             = mem_q[rd_ptr_q];
   assign bus.tvalid_o     = out_valid;
   assign bus.tdata_o      = out_valid ? head[BIT_D-1:0] : '0;
   assign bus.tlast_o      = out_valid & head[BIT_D];
   assign bus.level_o      = level_q;
   assign bus.frame_len_o  = frame_len_q;
   assign bus.frame_done_o = frame_done_q;
   assign bus.frame_act_o  = (state_q == ST_ACTIVE);
   assign bus.ovf_o        = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_roi_axis_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_roi_axis_fifo : vector table, corner sequences and random run vs a queue model
// rev 1.0
// ---------------------------------------------------------------------------
module tb_roi_axis_fifo;
   localparam int  BIT_D   = 8;
   localparam int  DEPTH   = 16;
   localparam int  CNT_W   = 21;
   localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

   logic clk;
   logic arst_n;

   roi_axis_fifo_if #(.BIT_D(BIT_D), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

   roi_axis_fifo #(.BIT_D(BIT_D), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk_i  (clk),
      .arst_i (arst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   // reference model: a plain queue of {tlast, tdata} plus frame bookkeeping
   logic [BIT_D:0] mq [$];
   logic           m_ovf;
   logic           m_act;
   logic           m_done;
   longint         m_pix;
   longint         m_len;

   typedef struct {
      logic       tv;
      logic [7:0] td;
      logic       tl;
      logic       tr;
      logic       clr;
      logic       e_tv;
      logic [7:0] e_td;
      logic       e_tl;
      logic [4:0] e_lvl;
      logic [20:0] e_len;
      logic       e_done;
      logic       e_act;
      logic       e_ovf;
   } vec_t;

   vec_t vt [7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_ovf = 0; m_act = 0; m_done = 0; m_pix = 0; m_len = 0;
   endtask

   // Apply one cycle of inputs, clock it, advance the model.
   task automatic apply(input logic tv, input logic [7:0] td, input logic tl,
                        input logic tr, input logic clr);
      logic rd, wr;
      longint sat;
      bus.tvalid_i  = tv;
      bus.tdata_i   = td;
      bus.tlast_i   = tl;
      bus.tready_i  = tr;
      bus.ovf_clr_i = clr;
      @(posedge clk);
      #1;
      rd = (mq.size() != 0) && tr;
      wr = tv && ((mq.size() < DEPTH) || rd);
      if (rd) void'(mq.pop_front());
      if (wr) mq.push_back({tl, td});
      if (tv && !wr)  m_ovf = 1'b1;
      else if (clr)   m_ovf = 1'b0;
      m_done = 1'b0;
      if (tv) begin
         sat = (m_pix == CNT_MAX) ? CNT_MAX : m_pix + 1;
         if (tl) begin
            m_len = sat; m_pix = 0; m_done = 1'b1; m_act = 1'b0;
         end else begin
            m_pix = sat; m_act = 1'b1;
         end
      end
   endtask

   task automatic check_model();
      chk("tvalid_o", bus.tvalid_o, mq.size() != 0);
      chk("level_o", bus.level_o, mq.size());
      if (mq.size() != 0) begin
         chk("tdata_o", bus.tdata_o, mq[0][7:0]);
         chk("tlast_o", bus.tlast_o, mq[0][8]);
      end else begin
         chk("tlast_o_empty", bus.tlast_o, 0);
      end
      chk("frame_len_o", bus.frame_len_o, m_len);
      chk("frame_done_o", bus.frame_done_o, m_done);
      chk("frame_act_o", bus.frame_act_o, m_act);
      chk("ovf_o", bus.ovf_o, m_ovf);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int beats;
      logic tv, tl, tr, clr;
      logic [7:0] td;

      //        tv td    tl tr clr | tv td    tl lvl len done act ovf
      vt[0] = '{1, 8'h10, 0, 1, 0,   1, 8'h10, 0, 1, 0, 0, 1, 0};
      vt[1] = '{1, 8'h11, 0, 1, 0,   1, 8'h11, 0, 1, 0, 0, 1, 0};
      vt[2] = '{1, 8'h12, 0, 1, 0,   1, 8'h12, 0, 1, 0, 0, 1, 0};
      vt[3] = '{1, 8'h13, 0, 1, 0,   1, 8'h13, 0, 1, 0, 0, 1, 0};
      vt[4] = '{1, 8'h14, 1, 1, 0,   1, 8'h14, 1, 1, 5, 1, 0, 0};
      vt[5] = '{0, 8'h00, 0, 1, 0,   0, 8'h00, 0, 0, 5, 0, 0, 0};
      vt[6] = '{0, 8'h00, 0, 1, 0,   0, 8'h00, 0, 0, 5, 0, 0, 0};

      arst_n = 1'b0;
      bus.tvalid_i = 0; bus.tdata_i = 0; bus.tlast_i = 0;
      bus.tready_i = 0; bus.ovf_clr_i = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_model();
      arst_n = 1'b1;

      // 5-beat frame through an always-ready sink
      for (int i = 0; i < 7; i++) begin
         apply(vt[i].tv, vt[i].td, vt[i].tl, vt[i].tr, vt[i].clr);
         chk("tbl_tvalid", bus.tvalid_o, vt[i].e_tv);
         if (vt[i].e_tv) chk("tbl_tdata", bus.tdata_o, vt[i].e_td);
         chk("tbl_tlast", bus.tlast_o, vt[i].e_tl);
         chk("tbl_level", bus.level_o, vt[i].e_lvl);
         chk("tbl_len", bus.frame_len_o, vt[i].e_len);
         chk("tbl_done", bus.frame_done_o, vt[i].e_done);
         chk("tbl_act", bus.frame_act_o, vt[i].e_act);
         chk("tbl_ovf", bus.ovf_o, vt[i].e_ovf);
      end

      // 20 beats into a stalled sink: first 16 kept
      for (int i = 0; i < 20; i++) begin
         apply(1, 8'(i), i == 19, 0, 0);
         check_model();
      end
      chk("stall_level", bus.level_o, 16);
      chk("stall_ovf", bus.ovf_o, 1);
      chk("stall_len", bus.frame_len_o, 20);
      chk("stall_done", bus.frame_done_o, 1);
      for (int k = 0; k < 16; k++) begin
         chk("drain_data", bus.tdata_o, k);
         chk("drain_last", bus.tlast_o, 0);
         apply(0, 0, 0, 1, 0);
         check_model();
      end
      chk("drain_empty", bus.level_o, 0);
      apply(0, 0, 0, 0, 1);
      chk("clr_ovf", bus.ovf_o, 0);

      // full FIFO with simultaneous read and write
      for (int i = 0; i < 16; i++) apply(1, 8'(8'h40 + i), 0, 0, 0);
      chk("fill_level", bus.level_o, 16);
      apply(1, 8'h50, 0, 1, 0);
      check_model();
      chk("rw_full_level", bus.level_o, 16);
      chk("rw_full_ovf", bus.ovf_o, 0);
      chk("rw_full_head", bus.tdata_o, 8'h41);

      // overflow set / clear / clear-vs-drop priority
      apply(1, 8'h51, 0, 0, 0);
      chk("drop_ovf", bus.ovf_o, 1);
      chk("drop_level", bus.level_o, 16);
      apply(0, 0, 0, 0, 1);
      chk("clr_nodrop", bus.ovf_o, 0);
      apply(1, 8'h52, 0, 0, 0);
      apply(1, 8'h53, 0, 0, 1);
      chk("clr_with_drop", bus.ovf_o, 1);
      apply(1, 8'h54, 1, 0, 0);
      check_model();
      chk("dropped_last_len", bus.frame_len_o, 21);
      chk("dropped_last_done", bus.frame_done_o, 1);
      chk("dropped_last_act", bus.frame_act_o, 0);

      // single-beat frame
      apply(1, 8'h55, 1, 1, 0);
      check_model();
      chk("single_len", bus.frame_len_o, 1);
      chk("single_act", bus.frame_act_o, 0);
      chk("single_done", bus.frame_done_o, 1);
      for (int k = 0; k < 17; k++) begin
         apply(0, 0, 0, 1, 0);
         check_model();
      end

      // asynchronous reset mid-frame
      for (int i = 0; i < 3; i++) apply(1, 8'(8'h60 + i), 0, 0, 0);
      chk("pre_rst_level", bus.level_o, 3);
      chk("pre_rst_act", bus.frame_act_o, 1);
      bus.tvalid_i = 0;
      arst_n = 1'b0;
      #2;
      chk("rst_tvalid", bus.tvalid_o, 0);
      chk("rst_level", bus.level_o, 0);
      chk("rst_tlast", bus.tlast_o, 0);
      chk("rst_tdata", bus.tdata_o, 0);
      chk("rst_len", bus.frame_len_o, 0);
      chk("rst_done", bus.frame_done_o, 0);
      chk("rst_act", bus.frame_act_o, 0);
      chk("rst_ovf", bus.ovf_o, 0);
      model_reset();
      @(posedge clk);
      #1;
      arst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         apply(1, 8'(8'h70 + i), i == 3, 1, 0);
         check_model();
      end
      chk("post_rst_len", bus.frame_len_o, 4);
      chk("post_rst_done", bus.frame_done_o, 1);

      // random traffic against the queue model
      beats = 0;
      for (int cyc = 0; beats < 1000 && cyc < 5000; cyc++) begin
         tv  = ($urandom_range(0, 3) != 0);
         td  = 8'($urandom);
         tl  = ($urandom_range(0, 7) == 0);
         tr  = ((cyc / 150) % 2 == 0) ? ($urandom_range(0, 4) != 0)
                                      : ($urandom_range(0, 3) == 0);
         clr = ($urandom_range(0, 15) == 0);
         apply(tv, td, tl, tr, clr);
         if (tv) beats++;
         check_model();
         chk("level_bound", bus.level_o <= DEPTH, 1);
      end
      chk("random_beats", beats, 1000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
`default_nettype wire
